// File: rtl/uart_tx_fifo.sv
// UART transmitter with a configurable frame format and an internal TX FIFO.
// Queued words go out back-to-back; tx is registered one edge behind the FSM state.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               sys_clk_100M,
  input  logic                               rst,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  function automatic logic f_parity(input logic [DATA_BITS-1:0] data);
    f_parity = (^data) ^ (PARITY == 1);
  endfunction

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [LW-1:0]        r_level;
  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_baud_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;

  logic w_full, w_empty, w_push, w_pop, w_bit_end, w_last_data, w_last_stop, w_tx_next;
  logic [DATA_BITS-1:0] w_head;

  assign w_full      = (r_level == FULL_LVL);
  assign w_empty     = (r_level == '0);
  assign w_push      = tx_valid & ~w_full;
  assign w_head      = r_mem[r_rptr];
  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_last_data = w_bit_end & (r_bit_cnt == DATA_LAST);
  assign w_last_stop = w_bit_end & (r_bit_cnt == STOP_LAST);

  assign tx_ready   = ~w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign fifo_level = r_level;

  // FIFO storage; flushing is done through the pointers, so the array needs no reset.
  always_ff @(posedge sys_clk_100M) begin
    if (w_push) r_mem[r_wptr] <= tx_data;
  end

  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge sys_clk_100M) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START; else w_next = S_IDLE;
      S_START: if (w_bit_end) w_next = S_DATA; else w_next = S_START;
      S_DATA: begin
        if (w_last_data) begin
          if (PARITY != 0) w_next = S_PAR; else w_next = S_STOP;
        end else begin
          w_next = S_DATA;
        end
      end
      S_PAR:   if (w_bit_end) w_next = S_STOP; else w_next = S_PAR;
      S_STOP: begin
        if (w_last_stop) begin
          if (!w_empty) w_next = S_START; else w_next = S_IDLE;
        end else begin
          w_next = S_STOP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A pop happens exactly on the edge that enters START, from IDLE or from the final stop bit.
  always_comb begin
    w_pop     = 1'b0;
    w_tx_next = 1'b1;
    case (r_state)
      S_IDLE:  begin w_pop = ~w_empty; w_tx_next = 1'b1; end
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = r_shift[0];
      S_PAR:   w_tx_next = r_par;
      S_STOP:  begin w_pop = w_last_stop & ~w_empty; w_tx_next = 1'b1; end
      default: begin w_pop = 1'b0; w_tx_next = 1'b1; end
    endcase
  end

  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE || w_bit_end) r_baud_cnt <= '0;
      else                                r_baud_cnt <= r_baud_cnt + CW'(1);
      if (r_state != w_next) r_bit_cnt <= '0;
      else if (w_bit_end)    r_bit_cnt <= r_bit_cnt + 4'd1;
      else                   r_bit_cnt <= r_bit_cnt;
    end
  end

  always_ff @(posedge sys_clk_100M) begin
    if (rst) begin
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= f_parity(w_head);
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
      r_tx <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter configurations sharing one clock; a line-level receiver decodes every
// frame against a queue of expected words, and channel 0 is tracked by a cycle-level FIFO model.
module tb_uart_tx_fifo;

  localparam int BD = 10;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] valid_v;
  logic [7:0] data0, data1, data2;
  logic [4:0] data3;
  wire  [3:0] ready_v, tx_v, busy_v;
  wire  [2:0] level0;
  wire  [4:0] level1, level2, level3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int seamless [4];

  logic [7:0] eq0[$], eq1[$], eq2[$], eq3[$];
  logic [7:0] mq0[$];
  int next_free0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sys_clk_100M(clk), .rst(rst), .tx_data(data0), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .fifo_level(level0));
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .sys_clk_100M(clk), .rst(rst), .tx_data(data1), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .fifo_level(level1));
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .sys_clk_100M(clk), .rst(rst), .tx_data(data2), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .fifo_level(level2));
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .sys_clk_100M(clk), .rst(rst), .tx_data(data3), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .fifo_level(level3));

  function automatic int db_of(input int c);
    return (c == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int c);
    return (c == 1) ? 2 : ((c == 2) ? 1 : 0);
  endfunction
  function automatic int sb_of(input int c);
    return (c == 3) ? 2 : 1;
  endfunction
  function automatic int nbits_of(input int c);
    return 1 + db_of(c) + ((par_of(c) != 0) ? 1 : 0) + sb_of(c);
  endfunction
  function automatic int frame_of(input int c);
    return BD * nbits_of(c);
  endfunction

  // Expected line pattern, bit 0 first: start 0, data LSB first, optional parity, stop ones.
  function automatic logic [11:0] exp_frame(input int c, input logic [7:0] d);
    logic [11:0] f;
    int pos;
    int ones;
    bit ev;
    f = '0;
    pos = 1;
    ones = 0;
    for (int i = 0; i < db_of(c); i++) begin
      f[pos] = d[i];
      ones += int'(d[i]);
      pos++;
    end
    ev = (ones % 2) == 1;
    if (par_of(c) != 0) begin
      f[pos] = (par_of(c) == 2) ? ev : ~ev;
      pos++;
    end
    for (int i = 0; i < sb_of(c); i++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input int c, input logic [7:0] d);
    case (c)
      0: eq0.push_back(d);
      1: eq1.push_back(d);
      2: eq2.push_back(d);
      3: eq3.push_back(d);
      default: ;
    endcase
  endtask

  task automatic exp_pop(input int c, output bit ok, output logic [7:0] d);
    ok = 1'b0;
    d = 8'h00;
    case (c)
      0: if (eq0.size() > 0) begin d = eq0.pop_front(); ok = 1'b1; end
      1: if (eq1.size() > 0) begin d = eq1.pop_front(); ok = 1'b1; end
      2: if (eq2.size() > 0) begin d = eq2.pop_front(); ok = 1'b1; end
      3: if (eq3.size() > 0) begin d = eq3.pop_front(); ok = 1'b1; end
      default: ;
    endcase
  endtask

  // Line receiver: detects start bits and samples each bit at its middle.
  initial begin : monitor
    bit act [4];
    int cnt [4];
    logic [11:0] rxv [4];
    int end_at [4];
    int ncyc;
    int n;
    bit ok;
    logic [7:0] d;
    ncyc = 0;
    for (int c = 0; c < 4; c++) begin
      act[c] = 1'b0; cnt[c] = 0; rxv[c] = '0; end_at[c] = -1; seamless[c] = 0;
    end
    forever begin
      @(negedge clk);
      ncyc++;
      for (int c = 0; c < 4; c++) begin
        if (rst === 1'b1) begin
          act[c] = 1'b0;
          end_at[c] = -1;
        end else begin
          if (!act[c] && tx_v[c] === 1'b0) begin
            act[c] = 1'b1;
            cnt[c] = 0;
            rxv[c] = '0;
            if (end_at[c] == ncyc) seamless[c]++;
          end
          if (act[c]) begin
            n = nbits_of(c);
            if (cnt[c] % BD == BD / 2) rxv[c][cnt[c] / BD] = tx_v[c];
            if (cnt[c] == BD * (n - 1) + BD / 2) begin
              exp_pop(c, ok, d);
              check($sformatf("frame_expected_ch%0d", c), 32'(ok), 32'd1);
              if (ok) check($sformatf("frame_ch%0d_data%02h", c, d), 32'(rxv[c]), 32'(exp_frame(c, d)));
              act[c] = 1'b0;
              end_at[c] = ncyc - cnt[c] + BD * n;
            end else begin
              cnt[c]++;
            end
          end
        end
      end
    end
  end

  // One clock of channel 0 with the FIFO model: pops when the transmitter is free.
  task automatic step0(input bit v, input logic [7:0] d);
    int t;
    bit rdy_m, push_m, pop_m;
    logic [7:0] tmp;
    t = cyc;
    valid_v[0] = v;
    data0 = d;
    rdy_m = (mq0.size() < 4);
    check("ready0", 32'(ready_v[0]), 32'(rdy_m));
    push_m = v && rdy_m;
    pop_m = (mq0.size() > 0) && (t >= next_free0);
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    if (pop_m) begin
      tmp = mq0.pop_front();
      next_free0 = t + frame_of(0);
    end
    if (push_m) begin
      mq0.push_back(d);
      exp_push(0, d);
    end
    check("level0", 32'(level0), 32'(mq0.size()));
    check("busy0", 32'(busy_v[0]), 32'((t < next_free0) || (mq0.size() != 0)));
  endtask

  task automatic drain0();
    int g;
    g = 0;
    while ((mq0.size() > 0 || cyc < next_free0) && g < 5000) begin
      step0(1'b0, 8'h00);
      g++;
    end
    check("drain0_in_time", 32'(g < 5000), 32'd1);
  endtask

  task automatic wait_monitor();
    int g;
    g = 0;
    while ((eq0.size() + eq1.size() + eq2.size() + eq3.size()) > 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("frames_received", 32'(eq0.size() + eq1.size() + eq2.size() + eq3.size()), 32'd0);
  endtask

  task automatic test_other(input int c, input logic [7:0] d);
    int n;
    logic [7:0] dm;
    dm = (c == 3) ? (d & 8'h1F) : d;
    check($sformatf("ready_ch%0d", c), 32'(ready_v[c]), 32'd1);
    valid_v[c] = 1'b1;
    case (c)
      1: data1 = d;
      2: data2 = d;
      3: data3 = d[4:0];
      default: ;
    endcase
    @(posedge clk);
    #1;
    valid_v[c] = 1'b0;
    exp_push(c, dm);
    n = 0;
    while (busy_v[c] === 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("frame_len_ch%0d", c), 32'(n), 32'(1 + frame_of(c)));
    check($sformatf("idle_tx_ch%0d", c), 32'(tx_v[c]), 32'd1);
  endtask

  initial begin : stim
    int t_push;
    int g;
    int snap;
    int bad;
    rst = 1'b1;
    valid_v = 4'h0;
    data0 = 8'h00; data1 = 8'h00; data2 = 8'h00; data3 = 5'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tx", 32'(tx_v), 32'hF);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_ready", 32'(ready_v), 32'hF);
    check("rst_levels", 32'({level0, level1, level2, level3}), 32'h0);

    // 8N1 0x55: latency, bit pattern and frame length
    t_push = cyc;
    step0(1'b1, 8'h55);
    step0(1'b0, 8'h00);
    check("latency_e1_tx", 32'(tx_v[0]), 32'd1);
    step0(1'b0, 8'h00);
    check("latency_e2_tx", 32'(tx_v[0]), 32'd0);
    g = 0;
    while (busy_v[0] === 1'b1 && g < 1000) begin
      step0(1'b0, 8'h00);
      g++;
    end
    check("frame_len_ch0", 32'(cyc - 1 - t_push), 32'(1 + frame_of(0)));
    check("idle_tx_ch0", 32'(tx_v[0]), 32'd1);
    drain0();
    wait_monitor();

    // parity and short-word/two-stop formats
    test_other(1, 8'h07);
    test_other(2, 8'h07);
    test_other(3, 8'h1F);
    test_other(3, 8'hE0);
    for (int c = 1; c < 4; c++) begin
      for (int k = 0; k < 3; k++) test_other(c, 8'($urandom));
    end
    wait_monitor();

    // fill from empty: 6 cycles of valid, back-to-back drain
    snap = seamless[0];
    for (int i = 0; i < 6; i++) step0(1'b1, 8'($urandom));
    check("ready_when_full", 32'(ready_v[0]), 32'd0);
    check("level_when_full", 32'(level0), 32'd4);
    drain0();
    wait_monitor();
    check("back_to_back_frames", 32'(seamless[0] - snap), 32'd4);

    // push and pop on the same edge at level 3, then pushes while full
    for (int i = 0; i < 4; i++) step0(1'b1, 8'($urandom));
    g = 0;
    while (cyc < next_free0 && g < 1000) begin
      step0(1'b0, 8'h00);
      g++;
    end
    step0(1'b1, 8'hA5);
    check("level_push_pop", 32'(level0), 32'd3);
    for (int i = 0; i < 3; i++) step0(1'b1, 8'($urandom));
    check("level_full_hold", 32'(level0), 32'd4);
    drain0();
    wait_monitor();

    // random traffic on channel 0
    for (int i = 0; i < 600; i++) step0($urandom_range(0, 3) == 0, 8'($urandom));
    drain0();
    wait_monitor();

    // reset mid-DATA with two words queued
    step0(1'b1, 8'h3C);
    step0(1'b1, 8'hC3);
    step0(1'b1, 8'h99);
    repeat (40) step0(1'b0, 8'h00);
    mq0.delete();
    eq0.delete();
    next_free0 = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_tx", 32'(tx_v[0]), 32'd1);
    check("midrst_level", 32'(level0), 32'd0);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_ready", 32'(ready_v[0]), 32'd1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step0(1'b0, 8'h00);
      if (tx_v[0] !== 1'b1) bad++;
    end
    check("no_frames_after_rst", 32'(bad), 32'd0);
    wait_monitor();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
